// File: rtl/seq_rec_trigger.sv
// seq_rec_trigger: masked pattern-match trigger ahead of the sequence recorder.
// Samples the recorder input bus, detects a rising match, waits a programmable
// delay and emits a one-cycle start pulse aligned with the re-timed sample.
module seq_rec_trigger #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned DLY_BITS = 16,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                SEQ_CLK,
  input  logic                SEQ_RST_N,
  input  logic [IN_BITS-1:0]  SEQ_IN,
  input  logic [IN_BITS-1:0]  CONF_PATTERN,
  input  logic [IN_BITS-1:0]  CONF_MASK,
  input  logic [DLY_BITS-1:0] CONF_DELAY,
  input  logic [DLY_BITS-1:0] CONF_HOLDOFF,
  input  logic                CONF_SINGLE,
  input  logic                ARM,
  input  logic                ABORT,
  output logic [IN_BITS-1:0]  SEQ_OUT,
  output logic                SEQ_EXT_START,
  output logic                ARMED,
  output logic                BUSY,
  output logic [CNT_BITS-1:0] TRIG_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DELAY   = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam logic [DLY_BITS-1:0] DLY_ONE = DLY_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DLY_BITS-1:0] r_cnt;
  logic [DLY_BITS-1:0] w_cnt_nxt;

  logic [IN_BITS-1:0]  r_in_q;
  logic [IN_BITS-1:0]  r_seq_out;
  logic                r_match_prev;
  logic                r_start;
  logic                r_armed;
  logic                r_busy;
  logic [CNT_BITS-1:0] r_trig_cnt;
  logic [CNT_BITS-1:0] w_trig_cnt_nxt;

  logic                w_match;
  logic                w_qualify;
  logic                w_fire;
  logic                w_arm_go;

  // Only masked bits take part; an all-zero mask matches every sample.
  assign w_match   = (((r_in_q ^ CONF_PATTERN) & CONF_MASK) == '0);
  assign w_qualify = w_match & ~r_match_prev;

  // State register and shared delay/holdoff down-counter
  always_ff @(posedge SEQ_CLK) begin
    if (!SEQ_RST_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter load/decrement and fire decision
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    w_arm_go    = 1'b0;
    if (ABORT) begin
      // Abort wins over everything, including a fire due this edge.
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ARM) begin
            w_state_nxt = ST_ARMED;
            w_arm_go    = 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_qualify) begin
            if (CONF_DELAY == '0) begin
              w_fire = 1'b1;
            end else begin
              w_cnt_nxt   = CONF_DELAY - DLY_ONE;
              w_state_nxt = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (r_cnt == '0) begin
            w_fire = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - DLY_ONE;
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_cnt_nxt = r_cnt - DLY_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase

      // Fire from either ARMED (zero delay) or DELAY resolves the same way.
      if (w_fire) begin
        if (CONF_SINGLE) begin
          w_state_nxt = ST_IDLE;
        end else if (CONF_HOLDOFF == '0) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_cnt_nxt   = CONF_HOLDOFF - DLY_ONE;
          w_state_nxt = ST_HOLDOFF;
        end
      end
    end
  end

  // Trigger counter: cleared on arm, saturating increment on fire
  always_comb begin
    w_trig_cnt_nxt = r_trig_cnt;
    if (w_arm_go) begin
      w_trig_cnt_nxt = '0;
    end else if (w_fire && (r_trig_cnt != '1)) begin
      w_trig_cnt_nxt = r_trig_cnt + CNT_ONE;
    end
  end

  // Input re-timing, match history, start pulse and registered status decodes
  always_ff @(posedge SEQ_CLK) begin
    if (!SEQ_RST_N) begin
      r_in_q       <= '0;
      r_seq_out    <= '0;
      r_match_prev <= 1'b0;
      r_start      <= 1'b0;
      r_armed      <= 1'b0;
      r_busy       <= 1'b0;
      r_trig_cnt   <= '0;
    end else begin
      r_in_q       <= SEQ_IN;
      r_seq_out    <= r_in_q;
      // Cleared on arming so a match already present qualifies immediately.
      r_match_prev <= w_arm_go ? 1'b0 : w_match;
      r_start      <= w_fire;
      r_armed      <= (w_state_nxt == ST_ARMED);
      r_busy       <= (w_state_nxt == ST_DELAY) || (w_state_nxt == ST_HOLDOFF);
      r_trig_cnt   <= w_trig_cnt_nxt;
    end
  end

  assign SEQ_OUT       = r_seq_out;
  assign SEQ_EXT_START = r_start;
  assign ARMED         = r_armed;
  assign BUSY          = r_busy;
  assign TRIG_CNT      = r_trig_cnt;

endmodule

// File: tb/tb_seq_rec_trigger.sv
// Bench for seq_rec_trigger: directed scenarios followed by random traffic,
// predicted by an event-time reference model and checked via a scoreboard.
module tb_seq_rec_trigger;

  localparam int IN_BITS  = 8;
  localparam int DLY_BITS = 16;
  localparam int CNT_BITS = 2;
  localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [IN_BITS-1:0]  din;
  logic [IN_BITS-1:0]  pat;
  logic [IN_BITS-1:0]  mask;
  logic [DLY_BITS-1:0] dly;
  logic [DLY_BITS-1:0] hold;
  logic                single;
  logic                arm;
  logic                abort;
  logic [IN_BITS-1:0]  seq_out;
  logic                start;
  logic                armed;
  logic                busy;
  logic [CNT_BITS-1:0] trig_cnt;

  always #5 clk = ~clk;

  seq_rec_trigger #(
    .IN_BITS (IN_BITS),
    .DLY_BITS(DLY_BITS),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .SEQ_CLK      (clk),
    .SEQ_RST_N    (rst_n),
    .SEQ_IN       (din),
    .CONF_PATTERN (pat),
    .CONF_MASK    (mask),
    .CONF_DELAY   (dly),
    .CONF_HOLDOFF (hold),
    .CONF_SINGLE  (single),
    .ARM          (arm),
    .ABORT        (abort),
    .SEQ_OUT      (seq_out),
    .SEQ_EXT_START(start),
    .ARMED        (armed),
    .BUSY         (busy),
    .TRIG_CNT     (trig_cnt)
  );

  typedef struct {
    int               edge_no;
    bit               pulse;
    logic [IN_BITS-1:0] out;
    bit               armed;
    bit               busy;
    int               cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   e      = 0;

  // Reference model: absolute edge times for the pending fire and re-arm.
  logic [IN_BITS-1:0] m_inq;
  logic [IN_BITS-1:0] m_out;
  bit                 m_prev;
  bit                 m_armed;
  int                 m_fire;
  int                 m_rearm;
  int                 m_cnt;

  function automatic bit m_idle();
    return !m_armed && (m_fire < 0) && (m_rearm < 0);
  endfunction

  task automatic model_edge();
    bit   match_now;
    bit   qual;
    bit   pulse;
    bit   clr_prev;
    exp_t x;
    match_now = (((m_inq ^ pat) & mask) == 0);
    qual      = match_now && !m_prev;
    pulse     = 1'b0;
    clr_prev  = 1'b0;
    if (!rst_n) begin
      m_inq = '0; m_out = '0; m_prev = 1'b0;
      m_armed = 1'b0; m_fire = -1; m_rearm = -1; m_cnt = 0;
    end else begin
      m_out = m_inq;
      if (abort) begin
        m_armed = 1'b0; m_fire = -1; m_rearm = -1;
      end else if (m_idle()) begin
        if (arm) begin
          m_armed = 1'b1; m_cnt = 0; clr_prev = 1'b1;
        end
      end else begin
        if (m_armed && qual) begin
          m_armed = 1'b0;
          m_fire  = e + int'(dly);
        end
        if (m_rearm == e) begin
          m_armed = 1'b1; m_rearm = -1;
        end
        if (m_fire == e) begin
          pulse  = 1'b1;
          m_fire = -1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (single)         m_armed = 1'b0;
          else if (hold == 0) m_armed = 1'b1;
          else                m_rearm = e + int'(hold);
        end
      end
      m_prev = clr_prev ? 1'b0 : match_now;
      m_inq  = din;
    end
    x.edge_no = e;
    x.pulse   = pulse;
    x.out     = m_out;
    x.armed   = m_armed;
    x.busy    = (m_fire >= 0) || (m_rearm >= 0);
    x.cnt     = m_cnt;
    sb.push_back(x);
  endtask

  // Apply one cycle of inputs, let the edge happen, then predict its outcome.
  task automatic cyc(input bit r, input bit a, input bit ab, input logic [IN_BITS-1:0] d);
    rst_n = r; arm = a; abort = ab; din = d;
    @(posedge clk);
    e++;
    model_edge();
    #1;
  endtask

  task automatic idle_cycles(input int n, input logic [IN_BITS-1:0] d);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic chk(input string nm, input int edge_no, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errors++;
      $display("FAIL %s edge %0d got %0h exp %0h", nm, edge_no, got, exp_v);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        x = sb.pop_front();
        chk("start",    x.edge_no, int'(start),    int'(x.pulse));
        chk("seq_out",  x.edge_no, int'(seq_out),  int'(x.out));
        chk("armed",    x.edge_no, int'(armed),    int'(x.armed));
        chk("busy",     x.edge_no, int'(busy),     int'(x.busy));
        chk("trig_cnt", x.edge_no, int'(trig_cnt), x.cnt);
      end
    end
  end

  initial begin
    int unsigned sel;
    bit          r;
    bit          a;
    bit          ab;
    logic [IN_BITS-1:0] d;

    m_inq = '0; m_out = '0; m_prev = 1'b0; m_armed = 1'b0;
    m_fire = -1; m_rearm = -1; m_cnt = 0;
    pat = 8'hA5; mask = 8'hFF; dly = '0; hold = '0; single = 1'b1;

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);

    // Single shot, zero delay, exact pattern.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    idle_cycles(2, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    idle_cycles(5, 8'h00);

    // Partial mask, delay 5, second rising match during DELAY is ignored.
    pat = 8'h03; mask = 8'h0F; dly = 16'd5;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    idle_cycles(2, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'hF3);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h03);
    idle_cycles(8, 8'h00);

    // Continuous with holdoff 3: toggling input, then a held level.
    pat = 8'hA5; mask = 8'hFF; dly = '0; hold = 16'd3; single = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? 8'hA5 : 8'h00);
    idle_cycles(3, 8'h00);
    idle_cycles(20, 8'hA5);
    idle_cycles(3, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);

    // Holdoff 0 toggling: enough fires to saturate the 2-bit counter.
    hold = '0;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, (i % 2 == 0) ? 8'hA5 : 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);

    // Zero mask fires in the first armed cycle.
    mask = 8'h00; single = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 8'h5A);
    idle_cycles(4, 8'h5A);

    // Abort in the second DELAY cycle; then ARM+ABORT together.
    mask = 8'hFF; dly = 16'd5;
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h00);
    idle_cycles(8, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 8'hA5);
    idle_cycles(4, 8'h00);

    // Reset in the middle of DELAY, then a normal re-arm.
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    idle_cycles(3, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    idle_cycles(8, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    idle_cycles(9, 8'h00);

    // Random traffic; pattern and mask only move while idle.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 399) != 0);
      ab = ($urandom_range(0, 79) == 0);
      a  = ($urandom_range(0, 5) == 0);
      if (m_idle() && ($urandom_range(0, 3) == 0)) begin
        pat = 8'($urandom);
        sel = $urandom_range(0, 9);
        mask = (sel < 4) ? 8'hFF : (sel < 6) ? 8'h0F : (sel < 8) ? 8'hF0 :
               (sel == 8) ? 8'h00 : 8'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        dly    = ($urandom_range(0, 15) == 0) ? 16'd30 : 16'($urandom_range(0, 6));
        hold   = 16'($urandom_range(0, 5));
        single = ($urandom_range(0, 2) == 0);
      end
      sel = $urandom_range(0, 3);
      if (sel == 0)      d = pat;
      else if (sel == 1) d = pat ^ (8'h01 << $urandom_range(0, 7));
      else if (sel == 2) d = 8'h00;
      else               d = 8'($urandom);
      cyc(r, a, ab, d);
    end

    idle_cycles(40, 8'h00);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_rec_trigger.md
# seq_rec_trigger

Pattern-match trigger stage placed directly upstream of the sequence recorder in the SEQ_CLK domain. It samples the recorder input bus, detects a masked pattern, and after a programmable delay issues the one-cycle SEQ_EXT_START pulse that starts a recording. It also forwards the sampled bus, re-timed, so that the start pulse and the triggering sample reach the recorder in the same cycle. The block supports single-shot and continuous (re-arming with holdoff) modes and counts issued triggers.

## Interface
- IN_BITS, 8, width of the monitored and forwarded bus
- DLY_BITS, 16, width of the delay and holdoff counters
- CNT_BITS, 16, width of the trigger counter
- SEQ_CLK  in  1  single clock for the whole block
- SEQ_RST_N  in  1  synchronous, active-low reset
- SEQ_IN  in  IN_BITS  monitored bus
- CONF_PATTERN  in  IN_BITS  compare value
- CONF_MASK  in  IN_BITS  1 = bit participates in the compare
- CONF_DELAY  in  DLY_BITS  cycles from qualification to start pulse
- CONF_HOLDOFF  in  DLY_BITS  dead cycles after a fire (continuous mode)
- CONF_SINGLE  in  1  1 = return to IDLE after one fire
- ARM  in  1  pulse; IDLE -> ARMED
- ABORT  in  1  pulse; any state -> IDLE
- SEQ_OUT  out  IN_BITS  SEQ_IN delayed by 2 cycles, to recorder SEQ_IN
- SEQ_EXT_START  out  1  one-cycle start pulse, to recorder SEQ_EXT_START
- ARMED  out  1  high while in state ARMED
- BUSY  out  1  high in DELAY or HOLDOFF
- TRIG_CNT  out  CNT_BITS  fires since last arm, saturating

## Operation
- Input path: in_q <= SEQ_IN each cycle; SEQ_OUT <= in_q.
- match = ((in_q ^ CONF_PATTERN) & CONF_MASK) == 0. If CONF_MASK = 0, match is always 1.
- match_prev <= match each cycle. It is forced to 0 on the IDLE->ARMED transition.
- qualify = match & ~match_prev (rising edge of the match condition).
- States and transitions:
  - IDLE: on ARM -> ARMED, and TRIG_CNT <= 0.
  - ARMED: on qualify:
    - if CONF_DELAY = 0: fire now;
    - else cnt <= CONF_DELAY-1 and -> DELAY.
  - DELAY: if cnt = 0, fire; else cnt <= cnt-1.
  - HOLDOFF: if cnt = 0 -> ARMED; else cnt <= cnt-1.
- Fire (a single edge):
  - SEQ_EXT_START <= 1 for one cycle.
  - TRIG_CNT <= TRIG_CNT+1, saturating at all-ones.
  - Next state:
    - CONF_SINGLE = 1 -> IDLE;
    - else CONF_HOLDOFF = 0 -> ARMED;
    - else cnt <= CONF_HOLDOFF-1 and -> HOLDOFF.
- Qualify events in IDLE, DELAY or HOLDOFF are ignored and not queued.
- CONF_DELAY is captured at qualification and CONF_HOLDOFF at fire. CONF_PATTERN and CONF_MASK are used live and must be held static while not IDLE.
- ABORT has highest priority: the next state is IDLE, no pending pulse is issued, and TRIG_CNT is held.
- ARM together with ABORT -> IDLE. ARM outside IDLE is ignored.

## Timing
- Reset (SEQ_RST_N = 0 at an edge) forces:
  - state IDLE, cnt 0;
  - in_q, SEQ_OUT, match_prev, SEQ_EXT_START, TRIG_CNT all 0;
  - ARMED 0, BUSY 0.
- Reset mid-DELAY: no pulse is issued after reset.
- SEQ_IN value V is set up before edge k:
  - in_q = V after edge k;
  - SEQ_OUT = V after edge k+1.
- If V qualifies while ARMED, SEQ_EXT_START is high for exactly the cycle after edge k+1+CONF_DELAY. With CONF_DELAY = 0 it coincides with SEQ_OUT = V.
- Entering ARMED with the match already true qualifies in the first ARMED cycle.
- Continuous mode, CONF_HOLDOFF = H: ARMED is re-entered at fire edge + H. A new rising match is required; a level held through holdoff does not retrigger.
- ARMED and BUSY are registered state decodes that change on the same edge as the state.
- Delay and holdoff counters do not wrap: the maximum delay is 2^DLY_BITS-1 cycles.

## Test plan
- IN_BITS=8, PATTERN=0xA5, MASK=0xFF, DELAY=0, SINGLE=1; ARM, then drive SEQ_IN=0xA5 before edge k -> SEQ_EXT_START high only in the cycle after edge k+1, SEQ_OUT=0xA5 in that cycle, TRIG_CNT=1, state IDLE.
- DELAY=5, MASK=0x0F, PATTERN=0x03; drive SEQ_IN=0xF3 -> pulse after edge k+6; second 0x03 edge during DELAY is ignored (TRIG_CNT=1).
- Continuous, HOLDOFF=3; toggle SEQ_IN between 0x00 and 0xA5 every cycle -> fires spaced ≥4 cycles apart, ignored edges during HOLDOFF; level 0xA5 held 20 cycles -> exactly one fire.
- MASK=0x00 with ARM -> fire in the first ARMED cycle; TRIG_CNT saturation with CNT_BITS=2 -> stays 3 after 5 fires.
- ABORT in DELAY cycle 2 of 5 -> no pulse, IDLE next edge, TRIG_CNT unchanged; ARM+ABORT same cycle in IDLE -> stays IDLE.
- SEQ_RST_N low mid-DELAY -> all outputs 0 next edge, no pulse afterward; ARM after reset works normally.
